vector_load_unit: RTL and testbench

Streams a vector of 64-bit words (IEEE-754 doubles) out of the shared `Memory` block and presents them in order to a downstream compute stage over a valid/ready channel. It sits directly upstream of `Memory`'s read port, driving its `read_enable`/`address` handshake, and replaces ad-hoc per-word reads with a single start command that carries base, stride and length. A small internal FIFO decouples memory latency from consumer backpressure.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/vector_load_unit_if.sv | 30 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/vector_load_unit.sv | 127 ++++++++++++
 tb/tb_vector_load_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side constants and the vector loader state encoding.
package mem_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 64;
  localparam int WORD_BYTES = 8;
  localparam int ALIGN_BITS = $clog2(WORD_BYTES);

  // Low address bits that must be zero for an aligned 64-bit access
  localparam logic [ALIGN_BITS-1:0] ALIGN_MASK = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DRAIN
  } load_state_t;

  function automatic logic word_aligned(input logic [ALIGN_BITS-1:0] low_bits);
    return (low_bits & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/vector_load_unit_if.sv
// Memory read port and downstream element stream of the vector loader.
interface vector_load_unit_if #(
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) ();

  logic                  mem_read_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output mem_read_enable, mem_address,
    input  mem_read_data, mem_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read_enable, mem_address,
    output mem_read_data, mem_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; push and pop may coincide at any occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage is cleared on reset so the head reads zero while empty
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vector_load_unit.sv
// Strided vector reader: one outstanding memory read at a time, results
// buffered in a small FIFO and streamed out with a last-element marker.
module vector_load_unit #(
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  vector_load_unit_if.master    bus
);

  import mem_pkg::*;

  load_state_t           state_reg;
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  issued_reg;

  logic                  push;
  logic                  push_last;
  logic                  pop;
  logic                  pop_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;

  assign push      = (state_reg == ST_REQ) && bus.mem_read_enable && bus.mem_ready;
  assign push_last = ((issued_reg + LEN_WIDTH'(1)) == len_reg);
  assign pop       = bus.out_valid && bus.out_ready;
  assign pop_last  = pop && bus.out_last;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_last, bus.mem_read_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_last  = fifo_head[DATA_WIDTH];
  assign bus.out_data  = fifo_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= ST_IDLE;
      stride_reg          <= '0;
      len_reg             <= '0;
      issued_reg          <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      bus.mem_read_enable <= 1'b0;
      bus.mem_address     <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            stride_reg <= stride;
            len_reg    <= length;
            issued_reg <= '0;
            if (!word_aligned(base_addr[ALIGN_BITS-1:0]) ||
                !word_aligned(stride[ALIGN_BITS-1:0])) begin
              error <= 1'b1;
            end else if (length == '0) begin
              done <= 1'b1;
            end else begin
              state_reg           <= ST_REQ;
              busy                <= 1'b1;
              bus.mem_read_enable <= 1'b1;
              bus.mem_address     <= base_addr;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_ready) begin
            bus.mem_read_enable <= 1'b0;
            bus.mem_address     <= bus.mem_address + stride_reg;
            issued_reg          <= issued_reg + LEN_WIDTH'(1);
            state_reg           <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The final element may already be consumed during this gap cycle
          if (issued_reg == len_reg) begin
            if (pop_last) begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end else if (!fifo_full) begin
            state_reg           <= ST_REQ;
            bus.mem_read_enable <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop_last) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: latency-programmable memory model, output scoreboard,
// a command table and hand-built backpressure / restart / reset sequences.
module tb_vector_load_unit;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] stride = '0;
  logic [15:0] length = '0;
  logic        busy;
  logic        done;
  logic        error;

  vector_load_unit_if bus ();

  vector_load_unit #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (64),
    .LEN_WIDTH  (16),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] len;
    int          lat;
  } vec_t;

  logic [63:0] mem_arr [8192];
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int mem_lat = 1;
  int read_cnt = 0;
  int done_cnt = 0;
  int error_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Memory responder, pulse counters and output scoreboard, all on the falling edge
  task automatic env_loop();
    int   lat_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.mem_ready = 1'b0;
        lat_cnt = 0;
        continue;
      end
      if (done) done_cnt++;
      if (error) error_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("out: data=%h last=%0d", bus.out_data, bus.out_last);
          check("out_data", bus.out_data, e.data);
          check("out_last", 64'(bus.out_last), 64'(e.last));
        end
      end
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        lat_cnt = 0;
      end else if (bus.mem_read_enable) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_read_data = mem_arr[bus.mem_address[15:3]];
          read_cnt++;
          if (addr_q.size() == 0) check("unexpected_read", 64'd1, 64'd0);
          else check("mem_address", 64'(bus.mem_address), 64'(addr_q.pop_front()));
        end
      end
    end
  endtask

  task automatic queue_expect(input logic [15:0] b, input logic [15:0] s, input int len);
    for (int k = 0; k < len; k++) begin
      logic [15:0] a;
      exp_t e;
      a = b + 16'(k) * s;
      e.data = $realtobits(real'(a >> 3) * 1.5);
      e.last = (k == len - 1);
      addr_q.push_back(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_start(input logic [15:0] b, input logic [15:0] s, input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    stride = s;
    length = len;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'hDEAD;
    stride = 16'h0003;
    length = 16'h00FF;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic run_cmd(input logic [15:0] b, input logic [15:0] s, input logic [15:0] len,
                         input int lat);
    int   r0, d0, e0;
    logic bad;
    mem_lat = lat;
    bad = (b[2:0] != 3'd0) || (s[2:0] != 3'd0);
    r0 = read_cnt;
    d0 = done_cnt;
    e0 = error_cnt;
    $display("cmd: base=%h stride=%h len=%0d lat=%0d", b, s, len, lat);
    if (!bad) queue_expect(b, s, int'(len));
    issue_start(b, s, len);
    if (bad) begin
      check("error_pulse", 64'(error), 64'd1);
      check("busy_on_error", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("reads_on_error", 64'(read_cnt - r0), 64'd0);
      check("error_count", 64'(error_cnt - e0), 64'd1);
      check("done_on_error", 64'(done_cnt - d0), 64'd0);
    end else if (len == 16'd0) begin
      check("done_zero_len", 64'(done), 64'd1);
      check("busy_zero_len", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("reads_zero_len", 64'(read_cnt - r0), 64'd0);
      check("done_count_zero_len", 64'(done_cnt - d0), 64'd1);
    end else begin
      check("busy_running", 64'(busy), 64'd1);
      wait_done(d0, 2000, "cmd_done");
      check("busy_after_done", 64'(busy), 64'd0);
      check("reads_issued", 64'(read_cnt - r0), 64'(len));
      check("outputs_left", 64'(exp_q.size()), 64'd0);
      check("addresses_left", 64'(addr_q.size()), 64'd0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   r0, d0, n;

    vecs[0] = '{16'h0000, 16'h0008, 16'd10, 1};
    vecs[1] = '{16'hFFF0, 16'h0008, 16'd4,  2};
    vecs[2] = '{16'h0040, 16'h0018, 16'd5,  3};
    vecs[3] = '{16'h0000, 16'h0008, 16'd0,  1};
    vecs[4] = '{16'h0004, 16'h0008, 16'd3,  1};
    vecs[5] = '{16'h0008, 16'h000C, 16'd2,  1};

    for (int w = 0; w < 8192; w++) mem_arr[w] = $realtobits(real'(w) * 1.5);
    bus.out_ready = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_read_data = '0;
    fork
      env_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_mem_read_enable", 64'(bus.mem_read_enable), 64'd0);
    check("rst_mem_address", 64'(bus.mem_address), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i].base, vecs[i].stride, vecs[i].len, vecs[i].lat);

    // Consumer stalled: only FIFO_DEPTH reads may go out
    $display("seq: backpressure base=0100 stride=10 len=6");
    mem_lat = 2;
    bus.out_ready = 1'b0;
    r0 = read_cnt;
    d0 = done_cnt;
    queue_expect(16'h0100, 16'h0010, 6);
    issue_start(16'h0100, 16'h0010, 16'd6);
    repeat (60) @(posedge clk);
    #1;
    check("reads_while_stalled", 64'(read_cnt - r0), 64'(FIFO_DEPTH));
    check("enable_while_stalled", 64'(bus.mem_read_enable), 64'd0);
    check("valid_while_stalled", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    wait_done(d0, 2000, "stall_done");
    check("stall_total_reads", 64'(read_cnt - r0), 64'd6);
    check("stall_outputs_left", 64'(exp_q.size()), 64'd0);

    // A second start while busy must be ignored
    $display("seq: restart attempt mid-command");
    r0 = read_cnt;
    d0 = done_cnt;
    queue_expect(16'h0000, 16'h0008, 10);
    issue_start(16'h0000, 16'h0008, 16'd10);
    repeat (6) @(posedge clk);
    issue_start(16'h0200, 16'h0008, 16'd3);
    wait_done(d0, 2000, "restart_done");
    repeat (10) @(posedge clk);
    #1;
    check("restart_single_done", 64'(done_cnt - d0), 64'd1);
    check("restart_reads", 64'(read_cnt - r0), 64'd10);
    check("restart_outputs_left", 64'(exp_q.size()), 64'd0);
    check("restart_busy", 64'(busy), 64'd0);

    // Reset while the third element's read is pending
    $display("seq: reset during third read");
    r0 = read_cnt;
    queue_expect(16'h0000, 16'h0008, 10);
    issue_start(16'h0000, 16'h0008, 16'd10);
    n = 0;
    while (!((read_cnt - r0) == 2 && bus.mem_read_enable) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_third_req", 64'(n < 200), 64'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_enable", 64'(bus.mem_read_enable), 64'd0);
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    run_cmd(16'h0080, 16'h0008, 16'd5, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
